dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle MIPS core's data port and a slower backing data memory with a request/acknowledge handshake. Read hits return data combinationally in the same cycle. Read misses and all writes stall the core until the backing memory acknowledges. This block replaces the core's direct connection to the data memory once the memory gains multi-cycle latency.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_array.sv | 66 ++++++
 rtl/dcache.sv | 219 +++++++++++++++++++++
 tb/tb_dcache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data cache.
//   dcache_state_t   - controller states (IDLE, FILL, WTHRU, DONE)
//   DCACHE_LINES_DEF - default number of one-word lines
//   sat_inc          - saturating 32-bit increment for the optional statistics
//                      counters (built only when DCACHE_STATS_EN is defined)
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WTHRU = 2'd2,
    DONE  = 2'd3
  } dcache_state_t;

  localparam int unsigned DCACHE_LINES_DEF = 16;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/data/valid storage for the direct-mapped data cache.
//   clk      - clock, writes on rising edge
//   reset    - asynchronous active-low; clears every valid bit
//   rd_idx   - line index for the combinational read
//   rd_valid/rd_tag/rd_data - contents of line rd_idx
//   wr_en    - write strobe; writes tag and data, and marks the line valid
//   wr_idx/wr_tag/wr_data   - write port
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = DCACHE_LINES_DEF,
  parameter int IW    = $clog2(LINES),
  parameter int TW    = 30 - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data
);

  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;

  // Combinational read of the addressed line.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

  // Next valid vector: a write always leaves its line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only storage cleared by reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache between
// the core data port and a request/acknowledge backing memory.
//   clk, reset (async active-low)
//   cpu_re/cpu_we/cpu_addr/cpu_wdata - core request (held while stall is high)
//   cpu_rdata, stall                 - core response
//   mem_req/mem_we/mem_addr/mem_wdata - backing-memory request (registered)
//   mem_rdata, mem_ack               - backing-memory response
// Optional: DCACHE_STATS_EN adds saturating hit_cnt, miss_cnt, wr_cnt outputs.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = DCACHE_LINES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  dcache_state_t state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   resp_q, resp_d;

  logic [IW-1:0] idx_s;
  logic [TW-1:0] addr_tag_s;
  logic          line_valid_s;
  logic [TW-1:0] line_tag_s;
  logic [31:0]   line_data_s;
  logic          hit_s;
  logic          ack_s;
  logic          arr_we_s;
  logic [31:0]   arr_wdata_s;
  logic          hit_evt_s;
  logic          miss_evt_s;
  logic          wr_evt_s;
  logic          unused_addr_bits_s;

  assign idx_s              = cpu_addr[IW+1:2];
  assign addr_tag_s         = cpu_addr[31:IW+2];
  assign unused_addr_bits_s = ^cpu_addr[1:0];
  assign hit_s              = line_valid_s && (line_tag_s == addr_tag_s);
  // An acknowledge is only meaningful while a request is outstanding.
  assign ack_s              = mem_ack && mem_req_q;

  dcache_array #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .rd_data  (line_data_s),
    .wr_en    (arr_we_s),
    .wr_idx   (idx_s),
    .wr_tag   (addr_tag_s),
    .wr_data  (arr_wdata_s)
  );

  // Controller next-state, core response and memory request setup.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_d      = resp_q;
    stall       = 1'b0;
    cpu_rdata   = 32'd0;
    arr_we_s    = 1'b0;
    arr_wdata_s = cpu_wdata;
    hit_evt_s   = 1'b0;
    miss_evt_s  = 1'b0;
    wr_evt_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          // Every store goes through to memory, hit or miss.
          stall       = 1'b1;
          state_d     = WTHRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {cpu_addr[31:2], 2'b00};
          mem_wdata_d = cpu_wdata;
          wr_evt_s    = 1'b1;
        end else if (cpu_re) begin
          if (hit_s) begin
            cpu_rdata = line_data_s;
            hit_evt_s = 1'b1;
          end else begin
            stall      = 1'b1;
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_addr[31:2], 2'b00};
            miss_evt_s = 1'b1;
          end
        end else begin
          stall = 1'b0;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (ack_s) begin
          arr_we_s    = 1'b1;
          arr_wdata_s = mem_rdata;
          resp_d      = mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = FILL;
        end
      end
      WTHRU: begin
        stall = 1'b1;
        if (ack_s) begin
          // Write-update on a hit only; a miss never allocates.
          arr_we_s    = hit_s;
          arr_wdata_s = cpu_wdata;
          mem_req_d   = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = WTHRU;
        end
      end
      DONE: begin
        // Release the held instruction with the captured response.
        cpu_rdata = resp_q;
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Controller and memory-interface registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      resp_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_q      <= resp_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Saturating event counters.
  always_comb begin
    hit_cnt_d  = hit_evt_s  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
    miss_cnt_d = miss_evt_s ? sat_inc(miss_cnt_q) : miss_cnt_q;
    wr_cnt_d   = wr_evt_s   ? sat_inc(wr_cnt_q)   : wr_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      wr_cnt_q   <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wr_cnt   = wr_cnt_q;
`else
  logic unused_evt_s;
  assign unused_evt_s = hit_evt_s ^ miss_evt_s ^ wr_evt_s;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: self-checking bench for dcache (LINES = 16). The bench plays both
// the core and the backing memory; a reference model of the cache contents
// (per-index valid/tag/data arrays) and of the backing memory (associative
// array) predicts every response. Directed scenarios first, then random ops.
module tb_dcache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // reference model
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_resp;
  logic [31:0] backing [logic [31:0]];
  int          e_hit, e_miss, e_wr;

  dcache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wr_cnt    (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (backing.exists(wa)) return backing[wa];
    return wa * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_resp = 32'd0;
    e_hit = 0; e_miss = 0; e_wr = 0;
  endtask

  // One core access. n = cycles spent in FILL/WTHRU before mem_ack (n >= 1).
  task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int n, output int stall_cycles);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [31:0] wa, rd;
    bit          hit;
    idx = addr[5:2];
    tg  = addr[31:6];
    wa  = {addr[31:2], 2'b00};
    hit = m_valid[idx] && (m_tag[idx] == tg);
    rd  = mem_rd(wa);
    stall_cycles = 0;
    @(negedge clk);
    cpu_re = !is_wr; cpu_we = is_wr; cpu_addr = addr; cpu_wdata = wd; mem_ack = 1'b0;
    #1;
    if (!is_wr && hit) begin
      chk("hit_stall", {31'd0, stall}, 32'd0);
      chk("hit_rdata", cpu_rdata, m_data[idx]);
      chk("hit_no_req", {31'd0, mem_req}, 32'd0);
      e_hit++;
    end else begin
      chk("idle_stall", {31'd0, stall}, 32'd1);
      chk("idle_rdata", cpu_rdata, 32'd0);
      if (stall) stall_cycles++;
      if (is_wr) e_wr++; else e_miss++;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        mem_ack   = (k == n);
        mem_rdata = (k == n) ? rd : 32'hBAD0_BAD0;
        #1;
        chk("busy_stall", {31'd0, stall}, 32'd1);
        chk("req", {31'd0, mem_req}, 32'd1);
        chk("req_we", {31'd0, mem_we}, {31'd0, is_wr});
        chk("req_addr", mem_addr, wa);
        if (is_wr) chk("req_wdata", mem_wdata, wd);
        if (stall) stall_cycles++;
      end
      if (is_wr) begin
        backing[wa] = wd;
        if (hit) m_data[idx] = wd;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = rd;
        m_resp       = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("done_stall", {31'd0, stall}, 32'd0);
      chk("done_rdata", cpu_rdata, m_resp);
      chk("done_no_req", {31'd0, mem_req}, 32'd0);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
    #1;
    chk("idle_nostall", {31'd0, stall}, 32'd0);
    chk("idle_zero", cpu_rdata, 32'd0);
  endtask

  initial begin
    int sc;
    reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // stray acknowledge with nothing outstanding is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall}, 32'd0);

    // load miss with ack after 3 cycles, then repeated load hits
    backing[32'h40] = 32'hDEAD_BEEF;
    access(1'b0, 32'h40, 32'd0, 3, sc);
    chk("miss_stall_cycles", sc, 32'd4);
    chk("miss_data", m_resp, 32'hDEAD_BEEF);
    access(1'b0, 32'h40, 32'd0, 1, sc);
    chk("hit_stall_cycles", sc, 32'd0);

    // store to cached line updates it
    access(1'b1, 32'h40, 32'h1234_5678, 2, sc);
    chk("wr_stall_cycles", sc, 32'd3);
    access(1'b0, 32'h40, 32'd0, 1, sc);
    chk("wr_update_hit", sc, 32'd0);
    idle_cycle();
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'd2);
    chk("miss_cnt", miss_cnt, 32'd1);
    chk("wr_cnt", wr_cnt, 32'd1);
`endif

    // store to uncached 0x80 does not allocate
    access(1'b1, 32'h80, 32'hCAFE_F00D, 1, sc);
    access(1'b0, 32'h80, 32'd0, 2, sc);
    chk("no_alloc_miss", sc, 32'd3);

    // eviction: 0x40 and 0x80 share index 0
    access(1'b0, 32'h40, 32'd0, 1, sc);
    chk("evict_a", sc, 32'd2);
    access(1'b0, 32'h80, 32'd0, 1, sc);
    chk("evict_b", sc, 32'd2);
    access(1'b0, 32'h40, 32'd0, 1, sc);
    chk("evict_c", sc, 32'd2);
    idle_cycle();

    // reset during FILL
    @(negedge clk);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    repeat (2) @(negedge clk);
    #1;
    chk("fill_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    cpu_re = 1'b0;
    reset  = 1'b1;
    model_clear();
    access(1'b0, 32'h40, 32'd0, 2, sc);
    chk("post_rst_miss", sc, 32'd3);

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic [25:0] tg;
      logic [3:0]  ix;
      logic [1:0]  lo;
      tg = ($urandom_range(0, 4) == 4) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
      ix = 4'($urandom_range(0, 15));
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) idle_cycle();
      access($urandom_range(0, 2) == 0, {tg, ix, lo}, $urandom, $urandom_range(1, 4), sc);
    end
    idle_cycle();
`ifdef DCACHE_STATS_EN
    chk("rand_hit_cnt", hit_cnt, e_hit);
    chk("rand_miss_cnt", miss_cnt, e_miss);
    chk("rand_wr_cnt", wr_cnt, e_wr);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
